// File: rtl/vx_dispatchv_lane_sequencer_pkg.sv
// Shared types and helpers for the vector dispatch lane sequencer.
// Optional feature macro: VX_DISPATCHV_SKIP_EMPTY_EN (used by the top module).
`ifndef NUM_THREADS
`define NUM_THREADS 8
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef VX_DV_NUM_LANES
`define VX_DV_NUM_LANES 4
`endif

package vx_dispatchv_lane_sequencer_pkg;

   localparam int unsigned DV_NUM_THREADS = `NUM_THREADS;
   localparam int unsigned DV_XLEN        = `XLEN;
   localparam int unsigned DV_NUM_LANES   = `VX_DV_NUM_LANES;
   localparam int unsigned DV_BATCHES     = DV_NUM_THREADS / DV_NUM_LANES;
   localparam int unsigned DVPID_BITS     = (DV_BATCHES > 1) ? $clog2(DV_BATCHES) : 1;

   localparam int unsigned UUID_BITS = 44;
   localparam int unsigned NW_BITS   = 2;
   localparam int unsigned PC_BITS   = 32;
   localparam int unsigned OP_BITS   = 4;
   localparam int unsigned ARGS_BITS = 16;
   localparam int unsigned NR_BITS   = 6;
   localparam int unsigned NT_BITS   = (DV_NUM_THREADS > 1) ? $clog2(DV_NUM_THREADS) : 1;

   // full-warp packet carried on the dispatch channel
   typedef struct packed {
      logic [UUID_BITS-1:0]                        uuid;
      logic [NW_BITS-1:0]                          wis;
      logic [DV_NUM_THREADS-1:0]                   tmask;
      logic [PC_BITS-1:0]                          PC;
      logic [OP_BITS-1:0]                          op_type;
      logic [ARGS_BITS-1:0]                        op_args;
      logic                                        wb;
      logic [NR_BITS-1:0]                          rd;
      logic [NT_BITS-1:0]                          tid;
      logic [DV_NUM_THREADS-1:0][DV_XLEN-1:0]      rs1_data;
      logic [DV_NUM_THREADS-1:0][DV_XLEN-1:0]      rs2_data;
      logic [DV_NUM_THREADS-1:0][DV_XLEN-1:0]      rs3_data;
   } dispatchv_data_t;

   // one lane batch as presented to the execute datapath
   typedef struct packed {
      logic [UUID_BITS-1:0]                        uuid;
      logic [NW_BITS-1:0]                          wis;
      logic [DV_NUM_LANES-1:0]                     tmask;
      logic [PC_BITS-1:0]                          PC;
      logic [OP_BITS-1:0]                          op_type;
      logic [ARGS_BITS-1:0]                        op_args;
      logic                                        wb;
      logic [NR_BITS-1:0]                          rd;
      logic [NT_BITS-1:0]                          tid;
      logic [DV_NUM_LANES-1:0][DV_XLEN-1:0]        rs1_data;
      logic [DV_NUM_LANES-1:0][DV_XLEN-1:0]        rs2_data;
      logic [DV_NUM_LANES-1:0][DV_XLEN-1:0]        rs3_data;
      logic [DVPID_BITS-1:0]                       pid;
      logic                                        sop;
      logic                                        eop;
   } dispatchv_lane_t;

   // per-batch OR of the thread mask
   function automatic logic [DV_BATCHES-1:0] dv_batch_nz(input logic [DV_NUM_THREADS-1:0] tmask);
      logic [DV_BATCHES-1:0][DV_NUM_LANES-1:0] tm;
      logic [DV_BATCHES-1:0]                   nz;
      tm = tmask;
      nz = '0;
      for (int unsigned b = 0; b < DV_BATCHES; b++) nz[b] = |tm[b];
      return nz;
   endfunction

   // lowest set batch, 0 when none
   function automatic logic [DVPID_BITS-1:0] dv_first(input logic [DV_BATCHES-1:0] nz);
      logic [DVPID_BITS-1:0] k;
      logic                  found;
      k     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < DV_BATCHES; i++) begin
         if (!found && nz[i]) begin
            k     = DVPID_BITS'(i);
            found = 1'b1;
         end
      end
      return k;
   endfunction

   // highest set batch, 0 when none
   function automatic logic [DVPID_BITS-1:0] dv_last(input logic [DV_BATCHES-1:0] nz);
      logic [DVPID_BITS-1:0] k;
      k = '0;
      for (int unsigned i = 0; i < DV_BATCHES; i++) begin
         if (nz[i]) k = DVPID_BITS'(i);
      end
      return k;
   endfunction

   // lowest set batch above k, k itself when none
   function automatic logic [DVPID_BITS-1:0] dv_next(input logic [DV_BATCHES-1:0] nz,
                                                     input logic [DVPID_BITS-1:0] k);
      logic [DVPID_BITS-1:0] n;
      logic                  found;
      n     = k;
      found = 1'b0;
      for (int unsigned i = 0; i < DV_BATCHES; i++) begin
         if (!found && (i > 32'(k)) && nz[i]) begin
            n     = DVPID_BITS'(i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   // lane slice k of a packet; sop/eop left clear for the caller
   function automatic dispatchv_lane_t dv_slice(input dispatchv_data_t d,
                                                input logic [DVPID_BITS-1:0] k);
      logic [DV_BATCHES-1:0][DV_NUM_LANES-1:0]              tm;
      logic [DV_BATCHES-1:0][DV_NUM_LANES-1:0][DV_XLEN-1:0] r1, r2, r3;
      dispatchv_lane_t                                      l;
      tm         = d.tmask;
      r1         = d.rs1_data;
      r2         = d.rs2_data;
      r3         = d.rs3_data;
      l          = '0;
      l.uuid     = d.uuid;
      l.wis      = d.wis;
      l.tmask    = tm[k];
      l.PC       = d.PC;
      l.op_type  = d.op_type;
      l.op_args  = d.op_args;
      l.wb       = d.wb;
      l.rd       = d.rd;
      l.tid      = d.tid;
      l.rs1_data = r1[k];
      l.rs2_data = r2[k];
      l.rs3_data = r3[k];
      l.pid      = k;
      return l;
   endfunction

endpackage

// File: rtl/VX_dispatchV_if.sv
// Vector dispatch channel: valid/ready handshake carrying a full-warp packet.
interface VX_dispatchV_if ();

   logic                                              valid;
   vx_dispatchv_lane_sequencer_pkg::dispatchv_data_t data;
   logic                                              ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/VX_elastic_buffer.sv
// Small circular FIFO; ready_in means "not full", data_out shows the head.
module VX_elastic_buffer #(
   parameter int unsigned DATAW = 1,
   parameter int unsigned SIZE  = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   output logic             ready_in,
   input  logic [DATAW-1:0] data_in,
   output logic [DATAW-1:0] data_out,
   output logic             valid_out,
   input  logic             ready_out
);

   localparam int unsigned PTRW = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam int unsigned CNTW = $clog2(SIZE + 1);

   logic [DATAW-1:0] mem [SIZE];
   logic [PTRW-1:0]  rd_ptr, wr_ptr;
   logic [CNTW-1:0]  count;
   logic             push, pop;

   assign ready_in  = (count != CNTW'(SIZE));
   assign valid_out = (count != '0);
   assign push      = valid_in && ready_in;
   assign pop       = valid_out && ready_out;
   assign data_out  = mem[rd_ptr];

   // pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTRW'(SIZE - 1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PTRW'(SIZE - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CNTW'(push) - CNTW'(pop);
      end
   end

   // storage write
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/vx_dispatchv_lane_sequencer.sv
// Splits buffered full-warp vector packets into NUM_LANES-wide batches, one per cycle.
// Optional macro VX_DISPATCHV_SKIP_EMPTY_EN: skip batches whose tmask slice is zero.
module vx_dispatchv_lane_sequencer
   import vx_dispatchv_lane_sequencer_pkg::*;
#(
   parameter int unsigned NUM_LANES = DV_NUM_LANES,
   parameter int unsigned BUF_SIZE  = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   VX_dispatchV_if.slave                       dispatch_if,
   output logic                                exe_valid,
   output logic [UUID_BITS-1:0]                exe_uuid,
   output logic [NW_BITS-1:0]                  exe_wis,
   output logic [NUM_LANES-1:0]                exe_tmask,
   output logic [PC_BITS-1:0]                  exe_PC,
   output logic [OP_BITS-1:0]                  exe_op_type,
   output logic [ARGS_BITS-1:0]                exe_op_args,
   output logic                                exe_wb,
   output logic [NR_BITS-1:0]                  exe_rd,
   output logic [NT_BITS-1:0]                  exe_tid,
   output logic [NUM_LANES-1:0][DV_XLEN-1:0]   exe_rs1_data,
   output logic [NUM_LANES-1:0][DV_XLEN-1:0]   exe_rs2_data,
   output logic [NUM_LANES-1:0][DV_XLEN-1:0]   exe_rs3_data,
   output logic [DVPID_BITS-1:0]               exe_pid,
   output logic                                exe_sop,
   output logic                                exe_eop,
   input  logic                                exe_ready
);

   if ((NUM_LANES != DV_NUM_LANES) || ((DV_NUM_THREADS % NUM_LANES) != 0)) begin : g_bad_lanes
      $error("NUM_LANES must match the package lane count and divide NUM_THREADS");
   end
   if (BUF_SIZE < 1) begin : g_bad_buf
      $error("BUF_SIZE must be at least 1");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state;
   dispatchv_data_t head, cur_pkt;
   dispatchv_lane_t out_q, head_lane, next_lane;
   logic            buf_valid, buf_pop, exe_fire;
   logic [DV_BATCHES-1:0] head_nz, cur_nz;
   logic [DVPID_BITS-1:0] head_first, head_last, cur_next, cur_last;

   VX_elastic_buffer #(
      .DATAW ($bits(dispatchv_data_t)),
      .SIZE  (BUF_SIZE)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (dispatch_if.valid),
      .ready_in  (dispatch_if.ready),
      .data_in   (dispatch_if.data),
      .data_out  (head),
      .valid_out (buf_valid),
      .ready_out (buf_pop)
   );

   assign exe_fire = (state == SEND) && exe_ready;
   // the head leaves the buffer when it becomes the current packet
   assign buf_pop  = buf_valid && ((state == IDLE) || (exe_fire && out_q.eop));

   // batch selection: first/next/last emitted batch for the head and current packet
   always_comb begin
`ifdef VX_DISPATCHV_SKIP_EMPTY_EN
      head_nz = dv_batch_nz(head.tmask);
      cur_nz  = dv_batch_nz(cur_pkt.tmask);
`else
      head_nz = '1;
      cur_nz  = '1;
`endif
      head_first    = dv_first(head_nz);
      head_last     = dv_last(head_nz);
      cur_next      = dv_next(cur_nz, out_q.pid);
      cur_last      = dv_last(cur_nz);
      head_lane     = dv_slice(head, head_first);
      head_lane.sop = 1'b1;
      head_lane.eop = (head_first == head_last);
      next_lane     = dv_slice(cur_pkt, cur_next);
      next_lane.sop = 1'b0;
      next_lane.eop = (cur_next == cur_last);
   end

   // sequencer FSM with registered batch outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cur_pkt <= '0;
         out_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (buf_valid) begin
                  state   <= SEND;
                  cur_pkt <= head;
                  out_q   <= head_lane;
               end
            end
            SEND: begin
               if (exe_ready) begin
                  if (!out_q.eop) begin
                     out_q <= next_lane;
                  end else if (buf_valid) begin
                     cur_pkt <= head;
                     out_q   <= head_lane;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign exe_valid    = (state == SEND);
   assign exe_uuid     = out_q.uuid;
   assign exe_wis      = out_q.wis;
   assign exe_tmask    = out_q.tmask;
   assign exe_PC       = out_q.PC;
   assign exe_op_type  = out_q.op_type;
   assign exe_op_args  = out_q.op_args;
   assign exe_wb       = out_q.wb;
   assign exe_rd       = out_q.rd;
   assign exe_tid      = out_q.tid;
   assign exe_rs1_data = out_q.rs1_data;
   assign exe_rs2_data = out_q.rs2_data;
   assign exe_rs3_data = out_q.rs3_data;
   assign exe_pid      = out_q.pid;
   assign exe_sop      = out_q.sop;
   assign exe_eop      = out_q.eop;

endmodule

// File: tb/tb_vx_dispatchv_lane_sequencer.sv
// Directed bench for vx_dispatchv_lane_sequencer (NUM_THREADS=8, NUM_LANES=4).
module tb_vx_dispatchv_lane_sequencer;
   import vx_dispatchv_lane_sequencer_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic exe_ready;
   always #5 clk = ~clk;

   VX_dispatchV_if dispatch_if ();

   logic                          exe_valid, exe_wb, exe_sop, exe_eop;
   logic [UUID_BITS-1:0]          exe_uuid;
   logic [NW_BITS-1:0]            exe_wis;
   logic [3:0]                    exe_tmask;
   logic [PC_BITS-1:0]            exe_PC;
   logic [OP_BITS-1:0]            exe_op_type;
   logic [ARGS_BITS-1:0]          exe_op_args;
   logic [NR_BITS-1:0]            exe_rd;
   logic [NT_BITS-1:0]            exe_tid;
   logic [3:0][DV_XLEN-1:0]       exe_rs1_data, exe_rs2_data, exe_rs3_data;
   logic [DVPID_BITS-1:0]         exe_pid;

   vx_dispatchv_lane_sequencer #(.NUM_LANES(4), .BUF_SIZE(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .dispatch_if  (dispatch_if),
      .exe_valid    (exe_valid),
      .exe_uuid     (exe_uuid),
      .exe_wis      (exe_wis),
      .exe_tmask    (exe_tmask),
      .exe_PC       (exe_PC),
      .exe_op_type  (exe_op_type),
      .exe_op_args  (exe_op_args),
      .exe_wb       (exe_wb),
      .exe_rd       (exe_rd),
      .exe_tid      (exe_tid),
      .exe_rs1_data (exe_rs1_data),
      .exe_rs2_data (exe_rs2_data),
      .exe_rs3_data (exe_rs3_data),
      .exe_pid      (exe_pid),
      .exe_sop      (exe_sop),
      .exe_eop      (exe_eop),
      .exe_ready    (exe_ready)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // fired beats, sampled on the falling edge
   typedef struct {
      logic [15:0]           uuid;
      logic [DVPID_BITS-1:0] pid;
      logic                  sop;
      logic                  eop;
      logic [3:0]            tmask;
      int                    cyc;
   } beat_t;

   beat_t beats[$];
   int    cyc = 0;

   always @(negedge clk) begin
      beat_t b;
      cyc++;
      if (exe_valid && exe_ready) begin
         b.uuid  = exe_uuid[15:0];
         b.pid   = exe_pid;
         b.sop   = exe_sop;
         b.eop   = exe_eop;
         b.tmask = exe_tmask;
         b.cyc   = cyc;
         beats.push_back(b);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic dispatchv_data_t mk_pkt(input logic [15:0] uid, input logic [7:0] tm,
                                              input logic [7:0] base);
      dispatchv_data_t p;
      p         = '0;
      p.uuid    = UUID_BITS'(uid);
      p.wis     = NW_BITS'(uid);
      p.tmask   = tm;
      p.PC      = 32'h8000_0000 | 32'(uid);
      p.op_type = 4'h3;
      p.op_args = uid;
      p.wb      = 1'b1;
      p.rd      = NR_BITS'(uid);
      for (int i = 0; i < 8; i++) begin
         p.rs1_data[i] = 32'(base) + 32'(i);
         p.rs2_data[i] = 32'h1000 + 32'(i);
         p.rs3_data[i] = 32'h2000 + 32'(i);
      end
      return p;
   endfunction

   task automatic send(input dispatchv_data_t p);
      check("send_ready", 128'(dispatch_if.ready), 128'(1'b1));
      dispatch_if.valid = 1'b1;
      dispatch_if.data  = p;
      tick();
      dispatch_if.valid = 1'b0;
   endtask

   task automatic chk_beat(input string tag, input int idx, input logic [15:0] uid,
                           input logic pid, input logic sop, input logic eop, input logic [3:0] tm);
      if (idx < beats.size())
         check(tag, 128'({beats[idx].uuid, beats[idx].pid, beats[idx].sop, beats[idx].eop, beats[idx].tmask}),
               128'({uid, pid, sop, eop, tm}));
      else
         check({tag, "_missing"}, 128'(beats.size()), 128'(idx + 1));
   endtask

   // six beats from three full-mask packets, in consecutive cycles
   task automatic chk_six(input string tag, input logic [15:0] u0, input logic [15:0] u1,
                          input logic [15:0] u2);
      logic [15:0] u [3];
      u[0] = u0; u[1] = u1; u[2] = u2;
      check({tag, "_count"}, 128'(beats.size()), 128'(6));
      for (int i = 0; i < 6; i++) begin
         chk_beat($sformatf("%s_b%0d", tag, i), i, u[i/2], 1'(i % 2), (i % 2) == 0, (i % 2) == 1, 4'hF);
         if (i < beats.size() && i > 0)
            check($sformatf("%s_cyc%0d", tag, i), 128'(beats[i].cyc - beats[0].cyc), 128'(i));
      end
   endtask

   task automatic chk_b_stall(input string tag);
      check({tag, "_ctl"}, 128'({exe_valid, exe_pid, exe_sop, exe_eop, exe_tmask}),
            128'({1'b1, 1'b0, 1'b1, 1'b0, 4'hF}));
      check({tag, "_uuid"}, 128'(exe_uuid), 128'(16'h22));
      check({tag, "_rs1"}, 128'(exe_rs1_data), {32'h23, 32'h22, 32'h21, 32'h20});
   endtask

   initial begin
      reset             = 1'b1;
      exe_ready         = 1'b0;
      dispatch_if.valid = 1'b0;
      dispatch_if.data  = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_ctl", 128'({exe_valid, exe_pid, exe_sop, exe_eop}), 128'(0));
      check("rst_data", 128'({exe_uuid, exe_tmask, exe_PC}), 128'(0));
      check("rst_rs1", 128'(exe_rs1_data), 128'(0));
      check("rst_ready", 128'(dispatch_if.ready), 128'(1'b1));

      // basic two-batch split
      exe_ready = 1'b1;
      beats.delete();
      send(mk_pkt(16'h11, 8'hFF, 8'h00));
      check("lat_idle", 128'(exe_valid), 128'(1'b0));
      tick();
      check("b0_ctl", 128'({exe_valid, exe_pid, exe_sop, exe_eop, exe_tmask}),
            128'({1'b1, 1'b0, 1'b1, 1'b0, 4'hF}));
      check("b0_rs1", 128'(exe_rs1_data), {32'd3, 32'd2, 32'd1, 32'd0});
      check("b0_hdr", 128'({exe_uuid[15:0], exe_PC, exe_rd}), 128'({16'h11, 32'h8000_0011, 6'h11}));
      tick();
      check("b1_ctl", 128'({exe_valid, exe_pid, exe_sop, exe_eop, exe_tmask}),
            128'({1'b1, 1'b1, 1'b0, 1'b1, 4'hF}));
      check("b1_rs1", 128'(exe_rs1_data), {32'd7, 32'd6, 32'd5, 32'd4});
      check("b1_hdr", 128'({exe_uuid[15:0], exe_PC, exe_rd}), 128'({16'h11, 32'h8000_0011, 6'h11}));
      tick();
      check("b_done", 128'(exe_valid), 128'(1'b0));

      // stall on pid0 while the buffer fills
      exe_ready = 1'b0;
      beats.delete();
      send(mk_pkt(16'h22, 8'hFF, 8'h20));
      tick();
      chk_b_stall("stall0");
      dispatch_if.valid = 1'b1;
      dispatch_if.data  = mk_pkt(16'h33, 8'hFF, 8'h30);
      tick();
      chk_b_stall("stall1");
      dispatch_if.data  = mk_pkt(16'h44, 8'hFF, 8'h40);
      tick();
      dispatch_if.valid = 1'b0;
      chk_b_stall("stall2");
      check("full_ready", 128'(dispatch_if.ready), 128'(1'b0));
      tick();
      chk_b_stall("stall3");
      exe_ready = 1'b1;
      repeat (8) tick();
      chk_six("drain", 16'h22, 16'h33, 16'h44);
      check("drain_ready", 128'(dispatch_if.ready), 128'(1'b1));

      // back-to-back arrivals
      beats.delete();
      send(mk_pkt(16'h55, 8'hFF, 8'h50));
      send(mk_pkt(16'h66, 8'hFF, 8'h60));
      send(mk_pkt(16'h77, 8'hFF, 8'h70));
      repeat (8) tick();
      chk_six("b2b", 16'h55, 16'h66, 16'h77);

      // sparse masks
      beats.delete();
      send(mk_pkt(16'h88, 8'hF0, 8'h80));
      repeat (5) tick();
`ifdef VX_DISPATCHV_SKIP_EMPTY_EN
      check("f0_count", 128'(beats.size()), 128'(1));
      chk_beat("f0_b0", 0, 16'h88, 1'b1, 1'b1, 1'b1, 4'hF);
`else
      check("f0_count", 128'(beats.size()), 128'(2));
      chk_beat("f0_b0", 0, 16'h88, 1'b0, 1'b1, 1'b0, 4'h0);
      chk_beat("f0_b1", 1, 16'h88, 1'b1, 1'b0, 1'b1, 4'hF);
`endif

      beats.delete();
      send(mk_pkt(16'h99, 8'h00, 8'h90));
      repeat (5) tick();
`ifdef VX_DISPATCHV_SKIP_EMPTY_EN
      check("z_count", 128'(beats.size()), 128'(1));
      chk_beat("z_b0", 0, 16'h99, 1'b0, 1'b1, 1'b1, 4'h0);
`else
      check("z_count", 128'(beats.size()), 128'(2));
      chk_beat("z_b0", 0, 16'h99, 1'b0, 1'b1, 1'b0, 4'h0);
      chk_beat("z_b1", 1, 16'h99, 1'b1, 1'b0, 1'b1, 4'h0);
`endif

      beats.delete();
      send(mk_pkt(16'hAA, 8'h0F, 8'hA0));
      repeat (5) tick();
`ifdef VX_DISPATCHV_SKIP_EMPTY_EN
      check("0f_count", 128'(beats.size()), 128'(1));
      chk_beat("0f_b0", 0, 16'hAA, 1'b0, 1'b1, 1'b1, 4'hF);
`else
      check("0f_count", 128'(beats.size()), 128'(2));
      chk_beat("0f_b0", 0, 16'hAA, 1'b0, 1'b1, 1'b0, 4'hF);
      chk_beat("0f_b1", 1, 16'hAA, 1'b1, 1'b0, 1'b1, 4'h0);
`endif

      // reset mid-packet with one packet buffered
      exe_ready = 1'b0;
      send(mk_pkt(16'hBB, 8'hFF, 8'hB0));
      dispatch_if.valid = 1'b1;
      dispatch_if.data  = mk_pkt(16'hCC, 8'hFF, 8'hC0);
      tick();
      dispatch_if.valid = 1'b0;
      check("mid_pid0", 128'({exe_valid, exe_pid, exe_uuid[15:0]}), 128'({1'b1, 1'b0, 16'hBB}));
      exe_ready = 1'b1;
      tick();
      check("mid_pid1", 128'({exe_valid, exe_pid, exe_uuid[15:0]}), 128'({1'b1, 1'b1, 16'hBB}));
      reset     = 1'b1;
      exe_ready = 1'b0;
      tick();
      check("mrst_valid", 128'(exe_valid), 128'(1'b0));
      check("mrst_ready", 128'(dispatch_if.ready), 128'(1'b1));
      reset     = 1'b0;
      exe_ready = 1'b1;
      beats.delete();
      repeat (5) tick();
      check("mrst_nobeats", 128'(beats.size()), 128'(0));
      check("mrst_idle", 128'(exe_valid), 128'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
